regfile_dump_reader: RTL and testbench

- Read-side master for the 32 x 64-bit register file.
- On a start pulse, walks an inclusive range of register indices and drives the register file's combinational read-address port.
- Captures each returned word and streams it out over a valid/ready interface as {index, data, last}.
- Used by debug/scan logic and testbenches to dump architectural state without touching the write path.

---
 rtl/regdump_pkg.sv | 27 ++
 rtl/regdump_index_counter.sv | 67 ++++++
 rtl/regfile_dump_reader.sv | 181 ++++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump reader.
// Contents: index/data widths, register count, FSM state encoding,
// register index type and a wrapping increment helper.
package regdump_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } regdump_state_t;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  // Next register index, wrapping NUM_REGS-1 -> 0.
  function automatic reg_idx_t idx_wrap_inc(input reg_idx_t idx);
    if (idx == reg_idx_t'(NUM_REGS - 1)) begin
      return '0;
    end
    return idx + reg_idx_t'(1);
  endfunction

endpackage

// File: rtl/regdump_index_counter.sv
// Loadable wrapping register-index counter with an end-of-range flag.
// Ports:
//   clk, reset     clock, async active-low reset
//   load           latch load_val as the current index and load_end as the end
//   load_val       first index of the range
//   load_end       final index of the range (inclusive)
//   inc            advance the current index by one (wrapping)
//   next_idx_c     combinational wrapped successor of idx
//   next_at_end_c  combinational: successor equals the end index
//                  (REGDUMP_PREFETCH_EN builds only)
//   idx            current index (registered)
//   at_end         current index equals the end index (registered)
module regdump_index_counter
  import regdump_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  reg_idx_t load_val,
  input  reg_idx_t load_end,
  input  logic     inc,
  output reg_idx_t next_idx_c,
`ifdef REGDUMP_PREFETCH_EN
  output logic     next_at_end_c,
`endif
  output reg_idx_t idx,
  output logic     at_end
);

  reg_idx_t idx_q, idx_d;
  reg_idx_t end_q, end_d;
  logic     at_end_q;

  assign next_idx_c = idx_wrap_inc(idx_q);
`ifdef REGDUMP_PREFETCH_EN
  assign next_at_end_c = (next_idx_c == end_q);
`endif

  // Load takes priority over increment.
  always_comb begin
    idx_d = idx_q;
    end_d = end_q;
    if (load) begin
      idx_d = load_val;
      end_d = load_end;
    end else if (inc) begin
      idx_d = next_idx_c;
    end
  end

  // at_end is registered from the next-state values so it tracks idx exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q    <= '0;
      end_q    <= '0;
      at_end_q <= 1'b1;
    end else begin
      idx_q    <= idx_d;
      end_q    <= end_d;
      at_end_q <= (idx_d == end_d);
    end
  end

  assign idx    = idx_q;
  assign at_end = at_end_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side master that dumps an inclusive, wrapping range of the
// 32 x 64-bit register file as a valid/ready stream of {index, data, last}.
// Optional macro REGDUMP_PREFETCH_EN: read the next index while a beat is
// presented so back-to-back beats stream at one per cycle.
// Ports:
//   clk, reset             clock, async active-low reset
//   start                  dump request, sampled only in IDLE
//   first_reg, last_reg    inclusive index range, sampled with start
//   rd_addr / rd_data      combinational register-file read port
//   out_valid / out_ready  stream handshake
//   out_data, out_index    captured word and its index
//   out_last               beat carries last_reg
//   busy                   dump in progress (READ/PRESENT/DONE)
//   done                   one-cycle pulse after the final beat is accepted
module regfile_dump_reader
  import regdump_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  regdump_state_t    state_q, state_d;
  reg_idx_t          rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  reg_idx_t          out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic     cnt_load;
  logic     cnt_inc;
  reg_idx_t cur_idx;
  reg_idx_t next_idx_c;
  logic     at_end;
`ifdef REGDUMP_PREFETCH_EN
  logic     next_at_end_c;
`endif

  logic handshake;
  assign handshake = out_valid_q && out_ready;

  regdump_index_counter u_idx_cnt (
    .clk          (clk),
    .reset        (reset),
    .load         (cnt_load),
    .load_val     (first_reg),
    .load_end     (last_reg),
    .inc          (cnt_inc),
    .next_idx_c   (next_idx_c),
`ifdef REGDUMP_PREFETCH_EN
    .next_at_end_c(next_at_end_c),
`endif
    .idx          (cur_idx),
    .at_end       (at_end)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = PRESENT;
      PRESENT: begin
        if (handshake) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
`ifdef REGDUMP_PREFETCH_EN
            state_d = PRESENT;
`else
            state_d = READ;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; rd_addr is registered, so it is set one cycle ahead
  // to the index the next state will read.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd_addr_d = '0;
        if (start) begin
          cnt_load  = 1'b1;
          rd_addr_d = first_reg;
        end
      end
      READ: begin
        out_data_d  = rd_data;
        out_index_d = cur_idx;
        out_last_d  = at_end;
        out_valid_d = 1'b1;
`ifdef REGDUMP_PREFETCH_EN
        rd_addr_d   = next_idx_c;
`else
        rd_addr_d   = cur_idx;
`endif
      end
      PRESENT: begin
        if (handshake) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            rd_addr_d   = '0;
          end else begin
            cnt_inc = 1'b1;
`ifdef REGDUMP_PREFETCH_EN
            // rd_data already holds the successor index: present it now.
            out_data_d  = rd_data;
            out_index_d = next_idx_c;
            out_last_d  = next_at_end_c;
            rd_addr_d   = idx_wrap_inc(next_idx_c);
`else
            out_valid_d = 1'b0;
            rd_addr_d   = next_idx_c;
`endif
          end
        end
      end
      DONE:    rd_addr_d = '0;
      default: rd_addr_d = '0;
    endcase
  end

  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: dumps are queued as expected
// beat lists when started, and a monitor pops and compares every accepted beat.
module tb_regfile_dump_reader;
  import regdump_pkg::*;

`ifdef REGDUMP_PREFETCH_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_reg = '0;
  logic [ADDR_W-1:0] last_reg = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign rd_data = regs[rd_addr];

  regfile_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .first_reg(first_reg),
    .last_reg (last_reg),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              first;
  } beat_t;

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: sampled on the falling edge, where a visible valid&&ready
  // means the beat is accepted at the next rising edge.
  int                cyc = 0;
  int                last_hs = -1;
  bit                ready_run = 1'b0;
  bit                stalled = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_idx;
  logic              hold_last;

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (!reset) begin
      stalled = 1'b0;
      last_hs = -1;
    end else begin
      if (done) done_cnt++;
      if (sb_q.size() != 0) check("busy_during_dump", 64'(busy), 64'(1));
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", out_data, hold_data);
        check("stall_index", 64'(out_index), 64'(hold_idx));
        check("stall_last", 64'(out_last), 64'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("beat_unexpected_index", 64'(out_index), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = sb_q.pop_front();
          check("beat_index", 64'(out_index), 64'(b.idx));
          check("beat_data", out_data, b.data);
          check("beat_last", 64'(out_last), 64'(b.last));
          if (!b.first && ready_run && last_hs >= 0)
            check("beat_gap", 64'(cyc - last_hs), 64'(GAP));
        end
        last_hs   = cyc;
        ready_run = 1'b1;
        stalled   = 1'b0;
      end else begin
        if (!out_ready) ready_run = 1'b0;
        stalled   = out_valid && !out_ready;
        hold_data = out_data;
        hold_idx  = out_index;
        hold_last = out_last;
      end
    end
  end

  // Pulse start for one cycle and queue the expected beats.
  task automatic start_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    int    n;
    int    ix;
    beat_t b;
    n = ((int'(l) - int'(f) + int'(NUM_REGS)) % int'(NUM_REGS)) + 1;
    @(posedge clk); #1;
    start = 1'b1; first_reg = f; last_reg = l;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      ix      = (int'(f) + k) % int'(NUM_REGS);
      b.idx   = ADDR_W'(ix);
      b.data  = regs[ix];
      b.last  = (k == n - 1);
      b.first = (k == 0);
      sb_q.push_back(b);
    end
  endtask

  task automatic wait_done(input int d0);
    bit got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk); #1;
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'(1));
    if (got) begin
      check("done_queue_empty", 64'(sb_q.size()), 64'(0));
      check("busy_in_done", 64'(busy), 64'(1));
      @(negedge clk); #1;
      check("done_one_cycle", 64'(done), 64'(0));
      check("busy_after_done", 64'(busy), 64'(0));
      check("done_count", 64'(done_cnt - d0), 64'(1));
    end else begin
      sb_q.delete();
    end
  endtask

  task automatic run_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l, input bit spurious);
    int d0 = done_cnt;
    start_dump(f, l);
    check("start_busy", 64'(busy), 64'(1));
    check("start_valid_latency", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("first_valid_latency", 64'(out_valid), 64'(1));
    if (spurious) begin
      @(posedge clk); #1;
      start = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(d0);
  endtask

  task automatic preload_seq();
    for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = 64'h1000 + 64'(i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int d0;
    preload_seq();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_out_data", out_data, 64'(0));
    check("rst_out_index", 64'(out_index), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic range with continuous ready.
    ready_mode = 0;
    run_dump(5'd3, 5'd5, 1'b0);
    // Wrapping range.
    run_dump(5'd30, 5'd1, 1'b0);

    // Single register, consumer stalls for 5 cycles.
    ready_mode = 2;
    d0 = done_cnt;
    start_dump(5'd7, 5'd7);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", out_data, 64'h1007);
    end
    ready_mode = 0;
    wait_done(d0);

    // Start while busy is ignored.
    ready_mode = 1;
    run_dump(5'd10, 5'd14, 1'b1);

    // Async reset in the middle of a full dump.
    ready_mode = 0;
    start_dump(5'd0, 5'd31);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 5'd10) found = 1'b1;
    end
    check("reached_index10", 64'(found), 64'(1));
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    check("areset_valid", 64'(out_valid), 64'(0));
    check("areset_busy", 64'(busy), 64'(0));
    check("areset_done", 64'(done), 64'(0));
    check("areset_rd_addr", 64'(rd_addr), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    run_dump(5'd0, 5'd0, 1'b0);

    // Randomised contents, ranges and back-pressure.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = {$urandom(), $urandom()};
      ready_mode = (t % 3 == 0) ? 0 : 1;
      run_dump(ADDR_W'($urandom_range(0, NUM_REGS - 1)),
               ADDR_W'($urandom_range(0, NUM_REGS - 1)), 1'($urandom_range(0, 1)));
    end

    // Full sweep at maximum throughput.
    preload_seq();
    ready_mode = 0;
    run_dump(5'd0, 5'd31, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
